wb_port_arbiter: RTL

- Sole initiator on the register file write port (rd, data, RegWrite). Merges single-cycle writebacks from the pipeline WB stage with out-of-order results from a long-latency unit (mult/div).
- Buffers long-unit results in a small queue whenever the port is taken.
- Keeps a per-register pending scoreboard so hazard detection can stall readers of registers still in flight.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_port_arbiter_if.sv | 39 +++
 rtl/wb_queue.sv | 56 +++++
 rtl/wb_port_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

  localparam int REG_AW           = 5;
  localparam int DATA_W           = 32;
  localparam int QDEPTH_DEF       = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  // One pending long-unit writeback: destination register plus result.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the arbiter's pipeline, long-unit, scoreboard and regfile signals.
// Latency: n/a (wiring only).
// Backpressure: long-unit results are held by the source while lu_ready is low.
interface wb_port_arbiter_if;
  import wb_pkg::*;

  logic              pipe_we;
  logic [REG_AW-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [REG_AW-1:0] lu_rd;
  logic [DATA_W-1:0] lu_data;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              rs_busy;
  logic              rt_busy;
  logic              pipe_stall;
  logic [REG_AW-1:0] rd;
  logic [DATA_W-1:0] data;
  logic              RegWrite;

  // Arbiter side.
  modport slave (
    input  pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
    input  issue_valid, issue_rd, rs, rt,
    output lu_ready, rs_busy, rt_busy, pipe_stall, rd, data, RegWrite
  );

  // Pipeline / long-unit / regfile side.
  modport master (
    output pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
    output issue_valid, issue_rd, rs, rt,
    input  lu_ready, rs_busy, rt_busy, pipe_stall, rd, data, RegWrite
  );

endinterface

// File: rtl/wb_queue.sv
// Synchronous FIFO holding long-unit results that lost the write port.
// Latency: head visible the cycle after push into an empty queue.
// Backpressure: push ignored when full unless a pop frees the slot that cycle.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  wb_entry_t              i_din,
  input  logic                   i_pop,
  output wb_entry_t              o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // A full queue may still take a push when the head leaves in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Sole writer of the regfile port: pipeline WB first, then queued long-unit results, then bypass.
// Latency: 0 cycles for direct writes; scoreboard/queue state updates at the posedge.
// Backpressure: lu_ready low when the queue is full and not popping; WB_STARVE_GUARD_EN adds pipe_stall.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF
`ifdef WB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
) (
  input  logic              clock,
  input  logic              reset,
  wb_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(QDEPTH) + 1;

  wb_entry_t   w_head;
  wb_entry_t   w_lu_entry;
  logic [CW-1:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_stall;
  logic        w_pipe_go;
  logic        w_pop;
  logic        w_bypass;
  logic        w_push;
  logic        w_lu_ready;
  logic [31:0] r_pending;
  logic [31:0] w_pend_clr;
  logic [31:0] w_pending_nxt;

  assign w_lu_entry = '{rd: bus.lu_rd, data: bus.lu_data};

  // Port priority and long-unit acceptance; everything is masked while reset is high.
  always_comb begin
    w_pipe_go  = !reset && bus.pipe_we && (bus.pipe_rd != '0) && !w_stall;
    w_pop      = !reset && !w_pipe_go && !w_empty;
    w_bypass   = !reset && !w_pipe_go && w_empty && bus.lu_valid && (bus.lu_rd != '0);
    w_lu_ready = !reset && ((w_count < CW'(QDEPTH)) || w_pop);
    // r0 results are accepted but never stored; bypassed results skip the queue.
    w_push     = w_lu_ready && bus.lu_valid && !w_bypass && (bus.lu_rd != '0) &&
                 (!w_full || w_pop);
  end

  // Regfile write mux; idle cycles drive zeros so the port is quiet.
  always_comb begin
    bus.rd       = '0;
    bus.data     = '0;
    bus.RegWrite = 1'b0;
    if (w_pipe_go) begin
      bus.rd       = bus.pipe_rd;
      bus.data     = bus.pipe_data;
      bus.RegWrite = 1'b1;
    end else if (w_pop) begin
      bus.rd       = w_head.rd;
      bus.data     = w_head.data;
      bus.RegWrite = 1'b1;
    end else if (w_bypass) begin
      bus.rd       = bus.lu_rd;
      bus.data     = bus.lu_data;
      bus.RegWrite = 1'b1;
    end
  end

  assign bus.lu_ready   = w_lu_ready;
  assign bus.pipe_stall = w_stall;

  wb_queue #(.DEPTH(QDEPTH)) u_queue (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_lu_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Scoreboard next state: long-unit writes clear, a same-cycle issue re-sets, r0 stays clear.
  always_comb begin
    w_pend_clr = '0;
    if (w_pop)    w_pend_clr[w_head.rd]  = 1'b1;
    if (w_bypass) w_pend_clr[bus.lu_rd]  = 1'b1;
    w_pending_nxt = r_pending & ~w_pend_clr;
    if (bus.issue_valid && (bus.issue_rd != '0)) w_pending_nxt[bus.issue_rd] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clock) begin
    if (reset) r_pending <= '0;
    else       r_pending <= w_pending_nxt;
  end

  // Hazard queries read registered state only, so a same-cycle clear is not visible.
  assign bus.rs_busy = !reset && r_pending[bus.rs];
  assign bus.rt_busy = !reset && r_pending[bus.rt];

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;

  // Count cycles the head waits; saturate at the limit and hold the stall until it pops.
  always_ff @(posedge clock) begin
    if (reset || w_pop || w_empty) r_starve <= '0;
    else if (r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + SW'(1);
  end

  assign w_stall = !reset && (r_starve == SW'(STARVE_LIMIT));
`else
  assign w_stall = 1'b0;
`endif

endmodule
